tl_protocol_checker: RTL
========================

Name: tl_protocol_checker

Overview:
- Parametrised, synthesizable TileLink-UL/UH protocol checker. It succeeds the fixed-width, assert-only monitor wrapper.
- Snoops one A/D channel pair, non-intrusively.
- Tracks in-flight transactions per source ID, counts multi-beat bursts on both channels, and flags a defined set of protocol violations.
- Each violation raises a sticky error bit and is also recorded as a first-error code. Both are readable by firmware or the bench.
- Instantiated beside any TL edge in the tile or subsystem; has no effect on traffic.

Parameters:
- SOURCE_BITS, 3: width of a_source/d_source; tracking table has 2^SOURCE_BITS entries.
- ADDR_BITS, 32: width of a_address.
- BEAT_BYTES, 4: data bus bytes per beat, a power of 2; LG_BEAT = log2(BEAT_BYTES).
- SIZE_BITS, 3: width of a_size/d_size (log2 bytes).
- TIMEOUT, 1024: cycles without a D last-beat while any source is in flight before error 7; 0 disables the check.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- a_valid, a_ready  in  1  A handshake; fire = valid&ready.
- a_opcode  in  3  A opcode.
- a_size  in  SIZE_BITS  A size.
- a_source  in  SOURCE_BITS  A source ID.
- a_address  in  ADDR_BITS  A address.
- d_valid, d_ready  in  1  D handshake.
- d_opcode  in  3  D opcode.
- d_size  in  SIZE_BITS  D size.
- d_source  in  SOURCE_BITS  D source ID.
- clear_err  in  1  synchronous clear of all error state.
- err  out  8  sticky per-code error flags.
- err_valid  out  1  at least one error has been latched since the last clear.
- err_first  out  3  code of the first error latched.
- inflight_cnt  out  SOURCE_BITS+1  number of sources currently in flight.

Behaviour:
- Reset: err=0, err_valid=0, err_first=0, inflight_cnt=0, all table entries invalid, both beat counters 0, watchdog 0.
- Beat count: beats(size) = 1 if size<=LG_BEAT, else 2^(size-LG_BEAT).
- A carries data for opcodes 0–3; D carries data only for opcode 1. Beats for a channel = beats(size) if that channel carries data, else 1.
- Burst tracking, per channel:
  - A beat counter is 0 at the first beat and increments on each fire.
  - The first beat captures opcode/size/source (plus address on A).
  - On the last beat the counter wraps to 0.
- A first-beat fire: source entry becomes valid and stores size plus the expected D opcode: Put(0,1)->0, Arith/Logic(2,3)->1, Get(4)->1, Intent(5)->2.
- D last-beat fire: the source entry is invalidated.
- inflight_cnt is the popcount of valid entries, registered, updated the cycle after the fire.
- Same-cycle A first-beat and D last-beat on the same source: D invalidate applies first, then A allocate. Entry stays valid and no error is raised.
- Error codes, each evaluated on fire and latched on the next clock edge:
  - 0: a_opcode in {6,7}.
  - 1: a_address not aligned to 2^a_size (first beat).
  - 2: A first beat to a source already valid (after same-cycle D release).
  - 3: D first beat to an invalid source.
  - 4: A non-first beat whose opcode/size/source differ from the captured values.
  - 5: D non-first beat whose opcode/size/source differ from the captured values.
  - 6: D first beat whose opcode or size mismatches the table entry.
  - 7: watchdog reached TIMEOUT.
- Errors on an offending beat do not block tracking:
  - Error 2 overwrites the entry.
  - Error 3 does not alter the table.
- Watchdog:
  - Increments each cycle while inflight_cnt!=0.
  - Resets to 0 on any D last-beat fire or when inflight_cnt==0.
  - Saturates at TIMEOUT and flags error 7 once per excursion.
- err_first: written only when err_valid is 0. Multiple codes in the same cycle record the lowest code.
- clear_err: zeros err, err_valid, err_first and the watchdog; tracking state is kept. clear_err wins over a same-cycle new error.
- reset_n low mid-burst: everything returns to reset values immediately. The next beat seen is treated as a first beat.
- Valid without ready: no state change.

Test Plan:
- Get size=2, source 3 with BEAT_BYTES=4, then AccessAckData size=2 source 3 -> inflight_cnt goes 1 then 0; err=0.
- PutFull size=4 (4 beats) with the source changed on beat 2 -> err[4]=1, err_first=4, err_valid=1; the A counter still wraps after beat 4.
- Get on source 1 answered by AccessAck (opcode 0) -> err[6]=1; entry freed; inflight_cnt=0.
- Two back-to-back Gets on source 2 with no D between them -> err[2]=1. A D on unused source 5 -> err[3]=1 also set, err_first stays 2.
- Get address 0x1002 size=2 -> err[1]=1. With TIMEOUT=16 and no response -> err[7] set 16 cycles after the A fire, once only.
- Same-cycle D last beat and A first beat on source 0 -> no error, inflight_cnt unchanged. clear_err with a simultaneous new error -> err=0.

Source files
------------

// File: rtl/tl_protocol_checker.sv
// Passive TileLink-UL/UH checker: tracks in-flight sources and burst beats on one A/D pair and
// latches sticky per-code protocol error flags plus the code of the first error seen.
module tl_protocol_checker #(
  parameter int unsigned SOURCE_BITS = 3,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned BEAT_BYTES  = 4,
  parameter int unsigned SIZE_BITS   = 3,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   clear_err,
  output logic [7:0]             err,
  output logic                   err_valid,
  output logic [2:0]             err_first,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int unsigned NumSrc  = 2 ** SOURCE_BITS;
  localparam int unsigned LgBeat  = $clog2(BEAT_BYTES);
  localparam int unsigned MaxSize = 2 ** SIZE_BITS - 1;
  localparam int unsigned CntW    = (MaxSize > LgBeat + 1) ? MaxSize - LgBeat : 1;
  localparam int unsigned WdW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef logic [CntW-1:0] cnt_t;

  // Index of the final beat of a burst; single-beat when the channel carries no data.
  function automatic cnt_t last_beat(input logic [SIZE_BITS-1:0] size, input logic has_data);
    cnt_t idx;
    idx = '0;
    if (has_data && 32'(size) > LgBeat) begin
      idx = cnt_t'((32'd1 << (32'(size) - LgBeat)) - 32'd1);
    end
    return idx;
  endfunction

  function automatic logic [2:0] exp_d_op(input logic [2:0] op);
    logic [2:0] r;
    case (op)
      3'd0, 3'd1:       r = 3'd0;
      3'd2, 3'd3, 3'd4: r = 3'd1;
      3'd5:             r = 3'd2;
      default:          r = 3'd0;
    endcase
    return r;
  endfunction

  cnt_t                   a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
  logic [2:0]             a_op_q, a_op_d, d_op_q, d_op_d;
  logic [SIZE_BITS-1:0]   a_size_q, a_size_d, d_size_q, d_size_d;
  logic [SOURCE_BITS-1:0] a_src_q, a_src_d, d_src_q, d_src_d;
  logic [NumSrc-1:0]      tbl_valid_q, tbl_valid_d;
  logic [SIZE_BITS-1:0]   tbl_size_q [NumSrc];
  logic [SIZE_BITS-1:0]   tbl_size_d [NumSrc];
  logic [2:0]             tbl_op_q [NumSrc];
  logic [2:0]             tbl_op_d [NumSrc];
  logic [SOURCE_BITS:0]   inflight_q, inflight_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic [7:0]             err_q, err_d;
  logic                   err_valid_q, err_valid_d;
  logic [2:0]             err_first_q, err_first_d;

  logic                   a_fire, a_first, a_last, d_fire, d_first, d_last, d_release;
  logic [SOURCE_BITS-1:0] d_src;
  logic [ADDR_BITS-1:0]   addr_mask;
  logic [7:0]             new_err;
  logic [2:0]             low_code;

  always_comb begin
    a_cnt_d     = a_cnt_q;
    d_cnt_d     = d_cnt_q;
    a_op_d      = a_op_q;
    a_size_d    = a_size_q;
    a_src_d     = a_src_q;
    d_op_d      = d_op_q;
    d_size_d    = d_size_q;
    d_src_d     = d_src_q;
    tbl_valid_d = tbl_valid_q;
    tbl_size_d  = tbl_size_q;
    tbl_op_d    = tbl_op_q;
    wd_d        = wd_q;
    err_d       = err_q;
    err_valid_d = err_valid_q;
    err_first_d = err_first_q;
    new_err     = '0;
    low_code    = '0;

    a_fire    = a_valid & a_ready;
    d_fire    = d_valid & d_ready;
    a_first   = (a_cnt_q == '0);
    d_first   = (d_cnt_q == '0);
    a_last    = a_first ? (a_cnt_q == last_beat(a_size, a_opcode <= 3'd3))
                        : (a_cnt_q == last_beat(a_size_q, a_op_q <= 3'd3));
    d_last    = d_first ? (d_cnt_q == last_beat(d_size, d_opcode == 3'd1))
                        : (d_cnt_q == last_beat(d_size_q, d_op_q == 3'd1));
    d_src     = d_first ? d_source : d_src_q;
    d_release = d_fire & d_last;
    addr_mask = ~({ADDR_BITS{1'b1}} << a_size);

    if (d_fire) begin
      if (d_first) begin
        d_op_d   = d_opcode;
        d_size_d = d_size;
        d_src_d  = d_source;
        if (!tbl_valid_q[d_source]) begin
          new_err[3] = 1'b1;
        end else if (d_opcode != tbl_op_q[d_source] || d_size != tbl_size_q[d_source]) begin
          new_err[6] = 1'b1;
        end
      end else if (d_opcode != d_op_q || d_size != d_size_q || d_source != d_src_q) begin
        new_err[5] = 1'b1;
      end
      d_cnt_d = d_last ? '0 : d_cnt_q + CntW'(1);
    end

    // Release before allocate so a same-cycle reuse of a source is legal.
    if (d_release) begin
      tbl_valid_d[d_src] = 1'b0;
    end

    if (a_fire) begin
      if (a_opcode >= 3'd6) begin
        new_err[0] = 1'b1;
      end
      if (a_first) begin
        a_op_d   = a_opcode;
        a_size_d = a_size;
        a_src_d  = a_source;
        if ((a_address & addr_mask) != '0) begin
          new_err[1] = 1'b1;
        end
        if (tbl_valid_d[a_source]) begin
          new_err[2] = 1'b1;
        end
        tbl_valid_d[a_source] = 1'b1;
        tbl_size_d[a_source]  = a_size;
        tbl_op_d[a_source]    = exp_d_op(a_opcode);
      end else if (a_opcode != a_op_q || a_size != a_size_q || a_source != a_src_q) begin
        new_err[4] = 1'b1;
      end
      a_cnt_d = a_last ? '0 : a_cnt_q + CntW'(1);
    end

    inflight_d = '0;
    for (int i = 0; i < NumSrc; i++) begin
      inflight_d = inflight_d + {{SOURCE_BITS{1'b0}}, tbl_valid_d[i]};
    end

    if (TIMEOUT == 0 || clear_err || d_release || inflight_q == '0) begin
      wd_d = '0;
    end else if (wd_q != WdW'(TIMEOUT)) begin
      wd_d = wd_q + WdW'(1);
      if (wd_q == WdW'(TIMEOUT - 1)) begin
        new_err[7] = 1'b1;
      end
    end

    for (int i = 7; i >= 0; i--) begin
      if (new_err[i]) begin
        low_code = 3'(i);
      end
    end

    if (clear_err) begin
      err_d       = '0;
      err_valid_d = 1'b0;
      err_first_d = '0;
    end else begin
      err_d = err_q | new_err;
      if (!err_valid_q && new_err != '0) begin
        err_valid_d = 1'b1;
        err_first_d = low_code;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_cnt_q     <= '0;
      d_cnt_q     <= '0;
      a_op_q      <= '0;
      a_size_q    <= '0;
      a_src_q     <= '0;
      d_op_q      <= '0;
      d_size_q    <= '0;
      d_src_q     <= '0;
      tbl_valid_q <= '0;
      for (int i = 0; i < NumSrc; i++) begin
        tbl_size_q[i] <= '0;
        tbl_op_q[i]   <= '0;
      end
      inflight_q  <= '0;
      wd_q        <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      err_first_q <= '0;
    end else begin
      a_cnt_q     <= a_cnt_d;
      d_cnt_q     <= d_cnt_d;
      a_op_q      <= a_op_d;
      a_size_q    <= a_size_d;
      a_src_q     <= a_src_d;
      d_op_q      <= d_op_d;
      d_size_q    <= d_size_d;
      d_src_q     <= d_src_d;
      tbl_valid_q <= tbl_valid_d;
      tbl_size_q  <= tbl_size_d;
      tbl_op_q    <= tbl_op_d;
      inflight_q  <= inflight_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      err_first_q <= err_first_d;
    end
  end

  assign err          = err_q;
  assign err_valid    = err_valid_q;
  assign err_first    = err_first_q;
  assign inflight_cnt = inflight_q;

endmodule
